vend_ctrl: RTL

Vending-machine transaction controller that sits directly upstream of the 3-digit display scanner. It accepts coin and button inputs, keeps the inserted credit, and vends one of two items when credit covers the price. It then returns change one unit at a time. Its `disp_val` output is the 12-bit binary value (0–999) that the display scanner converts to decimal and shows.

---
 rtl/vend_pkg.sv | 10 +
 rtl/edge_pulse.sv | 19 +
 rtl/vend_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin values and widths for the vending controller.
package vend_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, SHOW, VEND, CHANGE} state_t;
  localparam int CREDIT_W = 12;
  localparam logic [4:0] COIN1_V = 5'd1;
  localparam logic [4:0] COIN5_V = 5'd5;
  localparam logic [4:0] COIN10_V = 5'd10;
  localparam int PRICE_A_DEF = 25;
  localparam int PRICE_B_DEF = 40;
endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: registered one-cycle pulse on each rising edge of a level input.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_pulse
);
  logic r_q, r_p;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
      r_p <= 1'b0;
    end else begin
      r_q <= i_in;
      r_p <= i_in & ~r_q;
    end
  end
  assign o_pulse = r_p;
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin/button vending transaction controller driving a 3-digit display value.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_A    = PRICE_A_DEF,
  parameter int PRICE_B    = PRICE_B_DEF,
  parameter int MAX_CREDIT = 999,
  parameter int SHOW_CYC   = 100000,
  parameter int CHG_GAP    = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin1,
  input  logic                coin5,
  input  logic                coin10,
  input  logic                sel_a,
  input  logic                sel_b,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] disp_val,
  output logic                vend_a,
  output logic                vend_b,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy
);
  localparam int CNT_MAX = (SHOW_CYC > CHG_GAP) ? SHOW_CYC : CHG_GAP;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CREDIT_W-1:0] PA = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W-1:0] MC = CREDIT_W'(MAX_CREDIT);
  localparam logic [CNT_W-1:0] SHOW_LD = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(CHG_GAP - 1);
  logic [5:0] w_lvl, w_ev;
  assign w_lvl = {cancel, sel_b, sel_a, coin10, coin5, coin1};
  for (genvar g = 0; g < 6; g++) begin : g_ep
    edge_pulse u_ep (.clk(clk), .rst(rst), .i_in(w_lvl[g]), .o_pulse(w_ev[g]));
  end
  state_t              r_state, w_state;
  logic [CREDIT_W-1:0] r_credit, w_credit, w_sat, w_disp;
  logic [CREDIT_W:0]   w_add;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [4:0]          w_sum;
  logic                w_coin;
  logic                r_item_b, w_item_b, r_show_b, w_show_b;
  logic                w_vend_a, w_vend_b, w_chg, w_rej;
  assign w_sum = (w_ev[0] ? COIN1_V : 5'd0) + (w_ev[1] ? COIN5_V : 5'd0) + (w_ev[2] ? COIN10_V : 5'd0);
  assign w_coin = |w_ev[2:0];
  assign w_add = {1'b0, r_credit} + {{(CREDIT_W - 4){1'b0}}, w_sum};
  assign w_sat = (w_add > {1'b0, MC}) ? MC : w_add[CREDIT_W-1:0];
  always_comb begin
    w_state  = r_state;
    w_credit = r_credit;
    w_cnt    = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
    w_item_b = r_item_b;
    w_show_b = r_show_b;
    w_vend_a = 1'b0;
    w_vend_b = 1'b0;
    w_chg    = 1'b0;
    w_rej    = 1'b0;
    case (r_state)
      IDLE: if (w_coin) begin
        w_state  = COLLECT;
        w_credit = {{(CREDIT_W - 5){1'b0}}, w_sum};
      end
      COLLECT, SHOW: begin
        w_credit = w_sat;
        w_rej    = w_coin && (r_credit == MC);
        if (r_state == SHOW && r_cnt == '0) w_state = COLLECT;
        // Price checks use the credit held before this cycle's coins.
        if (w_ev[5]) begin
          w_state = CHANGE;
          w_cnt   = GAP_LD;
        end else if (w_ev[3] || w_ev[4]) begin
          w_item_b = ~w_ev[3];
          w_show_b = ~w_ev[3];
          w_state  = (r_credit >= (w_ev[3] ? PA : PB)) ? VEND : SHOW;
          w_cnt    = SHOW_LD;
        end
      end
      VEND: begin
        w_credit = r_credit - (r_item_b ? PB : PA);
        w_vend_a = ~r_item_b;
        w_vend_b = r_item_b;
        w_rej    = w_coin;
        w_state  = (w_credit != '0) ? CHANGE : IDLE;
        w_cnt    = GAP_LD;
      end
      CHANGE: begin
        w_rej = w_coin;
        if (r_cnt == '0) begin
          w_chg    = 1'b1;
          w_credit = r_credit - 1'b1;
          w_cnt    = GAP_LD;
          w_state  = (r_credit == 1) ? IDLE : CHANGE;
        end
      end
      default: w_state = IDLE;
    endcase
    w_disp = (w_state == SHOW) ? (w_show_b ? PB : PA) : (w_state == IDLE) ? '0 : w_credit;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_credit     <= '0;
      r_cnt        <= '0;
      r_item_b     <= 1'b0;
      r_show_b     <= 1'b0;
      disp_val     <= '0;
      vend_a       <= 1'b0;
      vend_b       <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_credit     <= w_credit;
      r_cnt        <= w_cnt;
      r_item_b     <= w_item_b;
      r_show_b     <= w_show_b;
      disp_val     <= w_disp;
      vend_a       <= w_vend_a;
      vend_b       <= w_vend_b;
      change_pulse <= w_chg;
      coin_reject  <= w_rej;
    end
  end
  assign busy = (r_state == VEND) || (r_state == CHANGE);
endmodule
